// File: rtl/jtkcpu_idxseq.sv
// Sequenced indexed-addressing unit for the KONAMI CPU core: decodes an indexed
// postbyte, fetches operand/indirect bytes over a byte read handshake, reports EA.
module jtkcpu_idxseq #(
   parameter int AW     = 16,
   parameter bit IND_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          start,
   input  logic [7:0]    postbyte,
   input  logic [AW-1:0] idx_reg,
   input  logic [AW-1:0] pc,
   input  logic [7:0]    a,
   input  logic [7:0]    b,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_ack,
   input  logic [7:0]    rd_data,
   output logic [AW-1:0] ea,
   output logic          busy,
   output logic          done,
   output logic          indirect,
   output logic          wb_en,
   output logic [AW-1:0] wb_val,
   output logic [1:0]    nbytes,
   output logic          illegal
);
   typedef enum logic [2:0] {IDLE, OP1, OP2, CALC, IND_HI, IND_LO, DONE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    pb_q, pb_d, hi_q, hi_d;
   logic [15:0]   op_q, op_d;
   logic [AW-1:0] ea_q, ea_d, wb_val_q, wb_val_d, rd_addr_q, rd_addr_d;
   logic          rd_req_q, rd_req_d, busy_q, busy_d, done_q, done_d;
   logic          wb_en_q, wb_en_d, illegal_q, illegal_d, ind_q, ind_d;
   logic [1:0]    nbytes_q, nbytes_d;
   logic [AW-1:0] calc_ea, calc_wb, rd_tgt, n8, n16;
   logic          rd_state, acked, wb_mode, ill_mode;

   function automatic logic [1:0] op_bytes(input logic [7:0] pb);
      if (pb[7]) return 2'd0;
      case (pb[3:0])
         4'h8, 4'hC:       return 2'd1;
         4'h9, 4'hD, 4'hF: return 2'd2;
         default:          return 2'd0;
      endcase
   endfunction

   // Operand bytes are shifted into op_q, so a single n8 lands in op_q[7:0].
   always_comb begin
      n8       = AW'($signed(op_q[7:0]));
      n16      = AW'($signed(op_q));
      wb_mode  = ~pb_q[7] & (pb_q[3:2] == 2'b00);
      ill_mode = ~pb_q[7] & ((pb_q[3:0] == 4'h7) | (pb_q[3:0] == 4'hA) | (pb_q[3:0] == 4'hE));
      case (pb_q[1:0])
         2'd0:    calc_wb = idx_reg + AW'(1);
         2'd1:    calc_wb = idx_reg + AW'(2);
         2'd2:    calc_wb = idx_reg - AW'(1);
         default: calc_wb = idx_reg - AW'(2);
      endcase
      calc_ea = idx_reg;
      if (pb_q[7]) calc_ea = idx_reg + AW'($signed(pb_q[4:0]));
      else begin
         case (pb_q[3:0])
            4'h2, 4'h3: calc_ea = calc_wb;
            4'h5:       calc_ea = idx_reg + AW'($signed(b));
            4'h6:       calc_ea = idx_reg + AW'($signed(a));
            4'hB:       calc_ea = idx_reg + AW'($signed({a, b}));
            4'h8:       calc_ea = idx_reg + n8;
            4'h9:       calc_ea = idx_reg + n16;
            4'hC:       calc_ea = pc + AW'(1) + n8;
            4'hD:       calc_ea = pc + AW'(2) + n16;
            4'hF:       calc_ea = AW'(op_q);
            default:    calc_ea = idx_reg;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      pb_d      = pb_q;
      hi_d      = hi_q;
      op_d      = op_q;
      ea_d      = ea_q;
      wb_val_d  = wb_val_q;
      rd_addr_d = rd_addr_q;
      rd_req_d  = rd_req_q;
      busy_d    = busy_q;
      nbytes_d  = nbytes_q;
      ind_d     = ind_q;
      done_d    = 1'b0;
      wb_en_d   = 1'b0;
      illegal_d = 1'b0;
      rd_state  = 1'b0;
      rd_tgt    = rd_addr_q;
      acked     = rd_req_q & rd_ack;
      // busy spans the done cycle, which also keeps a start there from being taken
      if (done_q) busy_d = 1'b0;
      case (state_q)
         IDLE: if (start && !busy_q) begin
            pb_d     = postbyte;
            op_d     = '0;
            busy_d   = 1'b1;
            ind_d    = IND_EN & postbyte[4] & ~postbyte[7];
            nbytes_d = op_bytes(postbyte);
            state_d  = (op_bytes(postbyte) != 2'd0) ? OP1 : CALC;
         end
         OP1: begin
            rd_state = 1'b1;
            rd_tgt   = pc;
            if (acked) begin
               op_d    = {op_q[7:0], rd_data};
               state_d = (nbytes_q == 2'd2) ? OP2 : CALC;
            end
         end
         OP2: begin
            rd_state = 1'b1;
            rd_tgt   = pc + AW'(1);
            if (acked) begin
               op_d    = {op_q[7:0], rd_data};
               state_d = CALC;
            end
         end
         CALC: begin
            ea_d = calc_ea;
            if (wb_mode) wb_val_d = calc_wb;
            state_d = ind_q ? IND_HI : DONE;
         end
         IND_HI: begin
            rd_state = 1'b1;
            rd_tgt   = ea_q;
            if (acked) begin
               hi_d    = rd_data;
               state_d = IND_LO;
            end
         end
         IND_LO: begin
            rd_state = 1'b1;
            rd_tgt   = ea_q + AW'(1);
            if (acked) begin
               ea_d    = AW'({hi_q, rd_data});
               state_d = DONE;
            end
         end
         DONE: begin
            done_d    = 1'b1;
            wb_en_d   = wb_mode;
            illegal_d = ill_mode;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Request is raised one cycle after entering a read state, so it drops for a cycle after every ack.
      if (acked) rd_req_d = 1'b0;
      else if (rd_state && !rd_req_q) begin
         rd_req_d  = 1'b1;
         rd_addr_d = rd_tgt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pb_q      <= '0;
         hi_q      <= '0;
         op_q      <= '0;
         ea_q      <= '0;
         wb_val_q  <= '0;
         rd_addr_q <= '0;
         rd_req_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         illegal_q <= 1'b0;
         ind_q     <= 1'b0;
         nbytes_q  <= '0;
      end else if (cen) begin
         state_q   <= state_d;
         pb_q      <= pb_d;
         hi_q      <= hi_d;
         op_q      <= op_d;
         ea_q      <= ea_d;
         wb_val_q  <= wb_val_d;
         rd_addr_q <= rd_addr_d;
         rd_req_q  <= rd_req_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wb_en_q   <= wb_en_d;
         illegal_q <= illegal_d;
         ind_q     <= ind_d;
         nbytes_q  <= nbytes_d;
      end
   end

   assign rd_req   = rd_req_q;
   assign rd_addr  = rd_addr_q;
   assign ea       = ea_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign indirect = ind_q;
   assign wb_en    = wb_en_q;
   assign wb_val   = wb_val_q;
   assign nbytes   = nbytes_q;
   assign illegal  = illegal_q;
endmodule

// File: doc/jtkcpu_idxseq.md
Name: jtkcpu_idxseq

Overview:
- Sequenced indexed-addressing unit for the KONAMI CPU core; next generation of the combinational index offset block.
- Takes an indexed postbyte and fetches 0–2 operand bytes over a byte-wide read handshake.
- Computes the effective address (EA) and, if selected, performs the two-byte indirect fetch.
- Reports auto-increment/decrement write-back for the index register and the operand-byte count, so the sequencer can advance PC.

Parameters:
AW, 16, address/register width (>=16); all EA arithmetic is modulo 2^AW.
IND_EN, 1, 1 = indirect modes enabled; 0 = postbyte[4] ignored, no indirect fetch, indirect output held 0.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cen  in  1  clock enable; all state advances only on clk edges with cen=1
start  in  1  begin decode of postbyte; sampled in IDLE only
postbyte  in  8  indexed postbyte, sampled with start
idx_reg  in  AW  selected index register value, stable from start to done
pc  in  AW  address of first byte after postbyte, stable from start to done
a  in  8  accumulator A
b  in  8  accumulator B
rd_req  out  1  memory read request
rd_addr  out  AW  read address, stable while rd_req=1
rd_ack  in  1  read accepted; rd_data valid in the same cen cycle
rd_data  in  8  read data
ea  out  AW  effective address; valid from done, held until next start
busy  out  1  high from accepted start until done cycle inclusive
done  out  1  one-cen-cycle pulse; EA final
indirect  out  1  registered postbyte[4]&IND_EN&~postbyte[7]
wb_en  out  1  pulses with done for auto-inc/dec modes
wb_val  out  AW  new index register value, valid with wb_en
nbytes  out  2  operand bytes consumed (0–2), valid with done
illegal  out  1  pulses with done for undefined mode codes

Behaviour:
- Reset: state IDLE; ea, wb_val, rd_addr = 0; rd_req, busy, done, wb_en, illegal, indirect = 0; nbytes = 0.
- Sign extension: 8-bit values (a, b, n8) are sign-extended to AW. n16 and D={a,b} are sign-extended from bit 15. Extended absolute n16 is zero-extended.
- postbyte[7]=1: offset = sign-extended postbyte[4:0]; EA = idx_reg+offset; no operand bytes, no indirect.
- postbyte[7]=0, mode = postbyte[3:0]:
  - 0000 ,R+: EA=R, wb=R+1
  - 0001 ,R++: EA=R, wb=R+2
  - 0010 ,-R: EA=wb=R-1
  - 0011 ,--R: EA=wb=R-2
  - 0100 ,R: EA=R
  - 0101 B,R / 0110 A,R / 1011 D,R: EA=R+register
  - 1000 n8,R: EA=R+n8 (1 byte)
  - 1001 n16,R: EA=R+n16 (2 bytes)
  - 1100 n8,PC: EA=pc+1+n8
  - 1101 n16,PC: EA=pc+2+n16
  - 1111 extended: EA=n16 absolute (2 bytes)
  - 0111, 1010, 1110: EA=R, illegal=1
- Operand bytes are read from pc, pc+1, big-endian (first byte = high).
- FSM states: IDLE, OP1, OP2, CALC, IND_HI, IND_LO, DONE.
  - IDLE --start--> OP1 if bytes>0, else CALC.
  - OP1 --ack--> OP2 if 2 bytes, else CALC.
  - OP2 --ack--> CALC.
  - CALC --> IND_HI if indirect, else DONE.
  - IND_HI --ack--> IND_LO. IND_LO --ack--> DONE. DONE --> IDLE.
- Read handshake: rd_req and rd_addr are registered. A request holds until a cen cycle with rd_ack=1. rd_req drops for one cycle after each ack.
- Indirect: reads EA then EA+1 (wraps mod 2^AW); EA becomes {hi,lo}, zero-extended.
- Latency with zero-wait ack: no-byte direct mode gives done 3 cen cycles after start. Each operand/indirect byte adds 2 cycles.
- wb_val wraps: R=max,+1 -> 0; R=0,-2 -> 2^AW-2.
- start while busy: ignored. start asserted in the done cycle: ignored, accepted the cycle after.
- rst mid-operation: immediate return to reset values; rd_req drops asynchronously.
- cen=0: all outputs hold; done/wb_en/illegal pulses extend until the next cen cycle.

Test Plan:
1. postbyte=0x9F (5-bit -1), R=0x1000 -> ea=0x0FFF, nbytes=0, no rd_req, done 3 cen cycles after start.
2. postbyte=0x01, R=0xFFFF -> ea=0xFFFF, wb_en=1, wb_val=0x0001; postbyte=0x03, R=0x0000 -> ea=wb_val=0xFFFE.
3. postbyte=0x09, pc=0x2000, mem[0x2000]=0x80, mem[0x2001]=0x00, R=0x9000 -> reads 0x2000 then 0x2001, ea=0x1000, nbytes=2.
4. postbyte=0x1F, pc=0x3000 holding 0xFFFF, mem[0xFFFF]=0x12, mem[0x0000]=0x34 -> indirect read wraps, ea=0x1234, indirect=1. Repeat with IND_EN=0 -> ea=0xFFFF, no indirect reads.
5. rd_ack withheld 5 cycles on postbyte=0x08 -> rd_req/rd_addr stable throughout. A second start during busy is ignored. rst asserted in OP1 -> all outputs 0 immediately.
6. postbyte=0x0B, a=0xFF, b=0xFE, R=0x0010, AW=20 -> ea=0xFFFFE+0x10 mod 2^20 = 0x0000E. postbyte=0x07 -> illegal pulse, ea=R.
